// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: operation encoding,
// FSM state encoding and byte-lane geometry.
package lsu_pkg;

  localparam int LANE_W      = 8;
  localparam int NUM_LANES   = 4;
  localparam int LSU_DATA_W  = LANE_W * NUM_LANES;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd7,
    OP_SH  = 4'd8,
    OP_SW  = 4'd9
  } lsu_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // True for the three store flavours; everything else reads memory.
  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Bundles for the load/store unit: the execute-stage request/response channel
// and the data-port bus towards the Harvard data memory.

// Request/response channel: the execute stage is the master, the LSU the slave.
interface lsu_req_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] rt_old;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  modport master (
    output req_valid, op, addr, store_data, rt_old,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, op, addr, store_data, rt_old,
    output req_ready, resp_valid, resp_data, resp_err
  );
endinterface

// Data-port bus: the LSU is the master, the memory the slave.
interface lsu_dp_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   dp_address;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                read_dp;
  logic                write_dp;
  logic [DATA_W-1:0]   dp_readdata;
  logic                stall;

  modport master (
    output dp_address, writedata, byteenable, read_dp, write_dp,
    input  dp_readdata, stall
  );

  modport slave (
    input  dp_address, writedata, byteenable, read_dp, write_dp,
    output dp_readdata, stall
  );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit: byte enables, store-data
// replication, load extraction/extension, LWL/LWR merging and the
// misalignment check. Works purely on the low two address bits.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [3:0]            op,
  input  logic [1:0]            o,
  input  logic [LSU_DATA_W-1:0] store_data,
  input  logic [LSU_DATA_W-1:0] rt_old,
  input  logic [LSU_DATA_W-1:0] rd,
  output logic [NUM_LANES-1:0]  byteenable,
  output logic [LSU_DATA_W-1:0] writedata,
  output logic [LSU_DATA_W-1:0] load_result,
  output logic                  misaligned
);

  logic [LSU_DATA_W-1:0] rd_shr;
  logic [LSU_DATA_W-1:0] rd_shl_lwl;
  logic [LSU_DATA_W-1:0] lwl_keep;
  logic [LSU_DATA_W-1:0] lwr_keep;

  // rd_shr brings the addressed lane down to bit 0; for LWL, ~o equals 3-o.
  // The LWL keep mask starts one lane lower so o=3 keeps nothing of rt_old.
  assign rd_shr     = rd >> {o, 3'b000};
  assign rd_shl_lwl = rd << {~o, 3'b000};
  assign lwl_keep   = 32'h00FF_FFFF >> {o, 3'b000};
  assign lwr_keep   = ~(32'hFFFF_FFFF >> {o, 3'b000});

  // Decode the operation into lane enables, write data and the load result.
  always_comb begin
    byteenable  = '0;
    writedata   = '0;
    load_result = '0;
    misaligned  = 1'b0;
    case (op)
      OP_LB: begin
        byteenable  = 4'b0001 << o;
        load_result = {{24{rd_shr[7]}}, rd_shr[7:0]};
      end
      OP_LBU: begin
        byteenable  = 4'b0001 << o;
        load_result = {24'h0, rd_shr[7:0]};
      end
      OP_LH: begin
        misaligned  = o[0];
        byteenable  = 4'b0011 << o;
        load_result = {{16{rd_shr[15]}}, rd_shr[15:0]};
      end
      OP_LHU: begin
        misaligned  = o[0];
        byteenable  = 4'b0011 << o;
        load_result = {16'h0, rd_shr[15:0]};
      end
      OP_LW: begin
        misaligned  = |o;
        byteenable  = 4'hF;
        load_result = rd;
      end
      OP_LWL: begin
        byteenable  = {o == 2'd3, o[1], |o, 1'b1};
        load_result = rd_shl_lwl | (rt_old & lwl_keep);
      end
      OP_LWR: begin
        byteenable  = 4'hF << o;
        load_result = rd_shr | (rt_old & lwr_keep);
      end
      OP_SB: begin
        byteenable = 4'b0001 << o;
        writedata  = {4{store_data[7:0]}};
      end
      OP_SH: begin
        misaligned = o[0];
        byteenable = 4'b0011 << o;
        writedata  = {2{store_data[15:0]}};
      end
      OP_SW: begin
        misaligned = |o;
        byteenable = 4'hF;
        writedata  = store_data;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// CPU-side initiator for the data port of the Harvard memory. Accepts one
// load/store at a time, issues a single word-aligned access (held through
// stall), and returns one response pulse. Misaligned or unknown operations
// are answered with an error and never reach the bus.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic       clk,
  input logic       rst,
  lsu_req_if.slave  req,
  lsu_dp_if.master  dp
);

  lsu_state_t state;
  lsu_state_t next_state;

  logic [3:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_data_q;
  logic [DATA_W-1:0] rt_old_q;
  logic [DATA_W-1:0] resp_data_q;
  logic              resp_err_q;

  logic                  accept;
  logic                  is_store_q;
  logic [3:0]            al_op;
  logic [1:0]            al_o;
  logic [NUM_LANES-1:0]  al_be;
  logic [DATA_W-1:0]     al_wdata;
  logic [DATA_W-1:0]     al_result;
  logic                  al_misaligned;

  // While idle the aligner looks at the incoming request so misalignment can
  // be decided at accept time; afterwards it works on the latched copy.
  assign accept     = req.req_valid && (state == IDLE);
  assign is_store_q = op_is_store(op_q);
  assign al_op      = (state == IDLE) ? req.op : op_q;
  assign al_o       = (state == IDLE) ? req.addr[1:0] : addr_q[1:0];

  lsu_align u_align (
    .op          (al_op),
    .o           (al_o),
    .store_data  (store_data_q),
    .rt_old      (rt_old_q),
    .rd          (dp.dp_readdata),
    .byteenable  (al_be),
    .writedata   (al_wdata),
    .load_result (al_result),
    .misaligned  (al_misaligned)
  );

  // State register; reset abandons any access in flight without a response.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic: IDLE -> ACCESS (or straight to RESP on error) -> RESP -> IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = al_misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        if (!dp.stall) next_state = RESP;
      end
      RESP: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Latch the request on accept and capture the response when the access ends.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= '0;
      addr_q       <= '0;
      store_data_q <= '0;
      rt_old_q     <= '0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q         <= req.op;
        addr_q       <= req.addr;
        store_data_q <= req.store_data;
        rt_old_q     <= req.rt_old;
        if (al_misaligned) begin
          resp_data_q <= '0;
          resp_err_q  <= 1'b1;
        end
      end
      if ((state == ACCESS) && !dp.stall) begin
        resp_data_q <= is_store_q ? '0 : al_result;
        resp_err_q  <= 1'b0;
      end
    end
  end

  // Bus and response outputs decode from state, so they are quiet outside
  // their phase and frozen through stall because the latched inputs are.
  always_comb begin
    req.req_ready  = (state == IDLE);
    req.resp_valid = 1'b0;
    req.resp_data  = '0;
    req.resp_err   = 1'b0;
    dp.dp_address  = '0;
    dp.byteenable  = '0;
    dp.writedata   = '0;
    dp.read_dp     = 1'b0;
    dp.write_dp    = 1'b0;
    if (state == ACCESS) begin
      dp.dp_address = {addr_q[ADDR_W-1:2], 2'b00};
      dp.byteenable = al_be;
      dp.writedata  = al_wdata;
      dp.read_dp    = !is_store_q;
      dp.write_dp   = is_store_q;
    end
    if (state == RESP) begin
      req.resp_valid = 1'b1;
      req.resp_data  = resp_data_q;
      req.resp_err   = resp_err_q;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model and
// a response scoreboard.
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];
  logic [7:0] mem_b [0:255];
  logic [31:0] got;

  lsu_req_if req_if ();
  lsu_dp_if  dp_if ();

  load_store_unit dut (
    .clk (clk),
    .rst (rst),
    .req (req_if.slave),
    .dp  (dp_if.master)
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read path: enabled lanes return data, disabled lanes read zero.
  always_comb begin
    dp_if.dp_readdata = '0;
    if (dp_if.read_dp) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_if.byteenable[i])
          dp_if.dp_readdata[8*i +: 8] = mem_b[{dp_if.dp_address[7:2], 2'(i)}];
      end
    end
  end

  // Memory write path: commit enabled lanes when the access completes.
  always @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 256; j++) mem_b[j] <= 8'h00;
    end else if (dp_if.write_dp && !dp_if.stall) begin
      for (int i = 0; i < 4; i++) begin
        if (dp_if.byteenable[i])
          mem_b[{dp_if.dp_address[7:2], 2'(i)}] <= dp_if.writedata[8*i +: 8];
      end
    end
  end

  // Global time limit so the run can never hang.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, watch the bus cycle by cycle, and score the response.
  task automatic applyStimulus(input string tag, input logic [3:0] op_i,
                               input logic [31:0] a, input logic [31:0] sd,
                               input logic [31:0] rt, input int stalls,
                               output logic [31:0] resp);
    logic [1:0]  o;
    logic        is_st;
    logic        mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    logic [31:0] exp_data;
    logic [7:0]  b [4];
    int          exp_lat;
    int          cyc;
    int          strobes;
    int          left;
    int          oi;
    exp_t        e;

    o     = a[1:0];
    oi    = int'(o);
    is_st = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW);
    case (op_i)
      OP_LH, OP_LHU, OP_SH:                   mis = o[0];
      OP_LW, OP_SW:                           mis = (o != 2'd0);
      OP_LB, OP_LBU, OP_SB, OP_LWL, OP_LWR:   mis = 1'b0;
      default:                                mis = 1'b1;
    endcase
    for (int i = 0; i < 4; i++) begin
      case (op_i)
        OP_LB, OP_LBU, OP_SB: exp_be[i] = (i == oi);
        OP_LH, OP_LHU, OP_SH: exp_be[i] = (i == oi) || (i == oi + 1);
        OP_LWL:               exp_be[i] = (i <= oi);
        OP_LWR:               exp_be[i] = (i >= oi);
        default:              exp_be[i] = 1'b1;
      endcase
      b[i] = mem_b[{a[7:2], 2'(i)}];
    end
    case (op_i)
      OP_SB:   exp_wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
      OP_SH:   exp_wd = {sd[15:0], sd[15:0]};
      default: exp_wd = sd;
    endcase
    exp_data = 32'h0;
    if (!mis && !is_st) begin
      case (op_i)
        OP_LB:  exp_data = {{24{b[oi][7]}}, b[oi]};
        OP_LBU: exp_data = {24'h0, b[oi]};
        OP_LH:  exp_data = {{16{b[oi+1][7]}}, b[oi+1], b[oi]};
        OP_LHU: exp_data = {16'h0, b[oi+1], b[oi]};
        OP_LW:  exp_data = {b[3], b[2], b[1], b[0]};
        OP_LWL: for (int j = 0; j < 4; j++)
                  exp_data[8*j +: 8] = (j >= 3 - oi) ? b[j - (3 - oi)] : rt[8*j +: 8];
        OP_LWR: for (int j = 0; j < 4; j++)
                  exp_data[8*j +: 8] = (j <= 3 - oi) ? b[j + oi] : rt[8*j +: 8];
        default: exp_data = 32'h0;
      endcase
    end
    exp_lat = mis ? 1 : 2 + stalls;
    e.data  = exp_data;
    e.err   = mis;
    sb.push_back(e);

    @(negedge clk);
    checkOutput({tag, ":ready"}, {31'h0, req_if.req_ready}, 32'h1);
    req_if.op         = op_i;
    req_if.addr       = a;
    req_if.store_data = sd;
    req_if.rt_old     = rt;
    req_if.req_valid  = 1'b1;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    cyc     = 1;
    strobes = 0;
    left    = stalls;
    while (!req_if.resp_valid && cyc < 40) begin
      if (dp_if.read_dp || dp_if.write_dp) strobes++;
      if (!mis) begin
        checkOutput({tag, ":read_dp"},  {31'h0, dp_if.read_dp},  {31'h0, !is_st});
        checkOutput({tag, ":write_dp"}, {31'h0, dp_if.write_dp}, {31'h0, is_st});
        checkOutput({tag, ":addr"},     dp_if.dp_address,        {a[31:2], 2'b00});
        checkOutput({tag, ":be"},       {28'h0, dp_if.byteenable}, {28'h0, exp_be});
        if (is_st) checkOutput({tag, ":wdata"}, dp_if.writedata, exp_wd);
      end
      dp_if.stall = (left > 0);
      if (left > 0) left--;
      @(negedge clk);
      cyc++;
    end
    dp_if.stall = 1'b0;
    checkOutput({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
    checkOutput({tag, ":strobes"}, 32'(strobes), mis ? 32'd0 : 32'(1 + stalls));
    checkOutput({tag, ":resp_quiet_bus"}, {31'h0, dp_if.read_dp | dp_if.write_dp}, 32'h0);
    resp = req_if.resp_data;
    if (req_if.resp_valid && sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput({tag, ":resp_data"}, req_if.resp_data, e.data);
      checkOutput({tag, ":resp_err"},  {31'h0, req_if.resp_err}, {31'h0, e.err});
    end
  endtask

  // Directed sequence.
  initial begin
    vectors          = 0;
    miscompares      = 0;
    rst              = 1'b1;
    dp_if.stall      = 1'b0;
    req_if.req_valid = 1'b0;
    req_if.op        = 4'h0;
    req_if.addr      = 32'h0;
    req_if.store_data = 32'h0;
    req_if.rt_old    = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("rst:req_ready",  {31'h0, req_if.req_ready},  32'h1);
    checkOutput("rst:resp_valid", {31'h0, req_if.resp_valid}, 32'h0);
    checkOutput("rst:resp_err",   {31'h0, req_if.resp_err},   32'h0);
    checkOutput("rst:resp_data",  req_if.resp_data,           32'h0);
    checkOutput("rst:read_dp",    {31'h0, dp_if.read_dp},     32'h0);
    checkOutput("rst:write_dp",   {31'h0, dp_if.write_dp},    32'h0);
    checkOutput("rst:be",         {28'h0, dp_if.byteenable},  32'h0);
    checkOutput("rst:addr",       dp_if.dp_address,           32'h0);
    checkOutput("rst:wdata",      dp_if.writedata,            32'h0);
    rst = 1'b0;

    applyStimulus("sw10", OP_SW, 32'h10, 32'hDEADBEEF, 32'h0, 0, got);
    applyStimulus("lw10", OP_LW, 32'h10, 32'h0, 32'h0, 0, got);
    checkOutput("lw10:const", got, 32'hDEADBEEF);

    applyStimulus("sb13", OP_SB, 32'h13, 32'h000000AB, 32'h0, 0, got);
    applyStimulus("lb13", OP_LB, 32'h13, 32'h0, 32'h0, 0, got);
    checkOutput("lb13:const", got, 32'hFFFFFFAB);
    applyStimulus("lbu13", OP_LBU, 32'h13, 32'h0, 32'h0, 0, got);
    checkOutput("lbu13:const", got, 32'h000000AB);

    applyStimulus("sw10b", OP_SW, 32'h10, 32'h80017F00, 32'h0, 0, got);
    applyStimulus("lh12", OP_LH, 32'h12, 32'h0, 32'h0, 0, got);
    checkOutput("lh12:const", got, 32'hFFFF8001);
    applyStimulus("lhu12", OP_LHU, 32'h12, 32'h0, 32'h0, 0, got);
    checkOutput("lhu12:const", got, 32'h00008001);
    applyStimulus("lh10", OP_LH, 32'h10, 32'h0, 32'h0, 0, got);
    checkOutput("lh10:const", got, 32'h00007F00);

    applyStimulus("lw22", OP_LW, 32'h22, 32'h0, 32'h0, 0, got);
    checkOutput("lw22:const", got, 32'h0);

    applyStimulus("sw20", OP_SW, 32'h20, 32'h44332211, 32'h0, 0, got);
    applyStimulus("lwl21", OP_LWL, 32'h21, 32'h0, 32'hAABBCCDD, 0, got);
    checkOutput("lwl21:const", got, 32'h2211CCDD);
    applyStimulus("lwr21", OP_LWR, 32'h21, 32'h0, 32'hAABBCCDD, 0, got);
    checkOutput("lwr21:const", got, 32'hAA443322);
    applyStimulus("lwl23", OP_LWL, 32'h23, 32'h0, 32'hAABBCCDD, 0, got);
    checkOutput("lwl23:const", got, 32'h44332211);
    applyStimulus("lwr20", OP_LWR, 32'h20, 32'h0, 32'hAABBCCDD, 0, got);
    checkOutput("lwr20:const", got, 32'h44332211);
    applyStimulus("lwl20", OP_LWL, 32'h20, 32'h0, 32'hAABBCCDD, 0, got);
    checkOutput("lwl20:const", got, 32'h11BBCCDD);

    applyStimulus("lw20st", OP_LW, 32'h20, 32'h0, 32'h0, 3, got);
    applyStimulus("sh12", OP_SH, 32'h12, 32'h00001234, 32'h0, 0, got);
    applyStimulus("lw10c", OP_LW, 32'h10, 32'h0, 32'h0, 0, got);
    checkOutput("lw10c:const", got, 32'h12347F00);
    applyStimulus("lh11", OP_LH, 32'h11, 32'h0, 32'h0, 0, got);
    applyStimulus("sw11", OP_SW, 32'h11, 32'h0BADF00D, 32'h0, 0, got);
    applyStimulus("opF", 4'hF, 32'h10, 32'h0, 32'h0, 0, got);
    applyStimulus("sb11st", OP_SB, 32'h11, 32'h000000C3, 32'h0, 2, got);
    applyStimulus("lbu11", OP_LBU, 32'h11, 32'h0, 32'h0, 1, got);
    checkOutput("lbu11:const", got, 32'h000000C3);

    // Reset in the middle of a stalled access: request dropped, no response.
    @(negedge clk);
    req_if.op        = OP_LW;
    req_if.addr      = 32'h20;
    req_if.req_valid = 1'b1;
    dp_if.stall      = 1'b1;
    @(negedge clk);
    req_if.req_valid = 1'b0;
    checkOutput("rstmid:read_before", {31'h0, dp_if.read_dp}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstmid:read_dp",   {31'h0, dp_if.read_dp},   32'h0);
    checkOutput("rstmid:write_dp",  {31'h0, dp_if.write_dp},  32'h0);
    checkOutput("rstmid:req_ready", {31'h0, req_if.req_ready}, 32'h1);
    rst         = 1'b0;
    dp_if.stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checkOutput("rstmid:no_resp", {31'h0, req_if.resp_valid}, 32'h0);
      @(negedge clk);
    end

    applyStimulus("lw10z", OP_LW, 32'h10, 32'h0, 32'h0, 0, got);
    checkOutput("lw10z:const", got, 32'h0);
    checkOutput("sb:empty", 32'(sb.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
